// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-addressed SRAM with programmable wait states.
// Illegal transfers (out of range, oversize, misaligned) get the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready_in,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int                BYTES    = DATA_W / 8;
  localparam int                LANE_W   = $clog2(BYTES);
  localparam int                IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(MEM_DEPTH * BYTES);
  localparam logic [2:0]        MAX_SIZE = 3'(LANE_W);
  localparam logic [2:0]        CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              accept;
  logic              valid;
  logic [ADDR_W-1:0] offset;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] size_mask;
  logic [BYTES-1:0]  be_nx;
  logic [BYTES-1:0]  be_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;

  // hburst and the BUSY/IDLE distinction carry no meaning for this slave.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  assign accept = hsel & hready_in & htrans[1];
  assign offset = haddr - BASE_ADDR;
  assign lane   = haddr[LANE_W-1:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    size_mask = '0;
    be_nx     = '0;
    for (int b = 0; b < LANE_W; b++) size_mask[b] = (b < int'(hsize));
    valid = (haddr >= BASE_ADDR) && (offset < SPAN) && (hsize <= MAX_SIZE) &&
            ((lane & size_mask) == '0);
    for (int b = 0; b < BYTES; b++)
      be_nx[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << hsize));
  end

  always_ff @(posedge hclk or posedge hreset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (hreset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      // These states end (or have no) data phase, so a new address phase can be taken.
      S_IDLE, S_DATA, S_ERR2: begin
        hresp    = (state == S_ERR2);
        state_nx = S_IDLE;
        if (accept) begin
          if (!valid) begin
            state_nx = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt == 3'd0) state_nx = S_DATA;
        else             cnt_nx   = cnt - 3'd1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nx  = S_ERR2;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      idx_q   <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else if (accept && valid && hreadyout) begin
      idx_q   <= offset[LANE_W +: IDX_W];
      be_q    <= be_nx;
      write_q <= hwrite;
    end
  end

  // NOTE: the SRAM array has no reset; its contents are undefined until written, like the real macro.
  // A write pending at reset is dropped because reset forces the state out of S_DATA asynchronously.
  always_ff @(posedge hclk) begin
    if (state == S_DATA && write_q) begin
      for (int b = 0; b < BYTES; b++)
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

  // Read data is taken straight from the array, so a write closing on the previous edge is already visible.
  always_comb begin
    hrdata = '0;
    if (state == S_DATA && !write_q) hrdata = mem[idx_q];
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized AHB-Lite master driving ahb_sram_slave, checked cycle by cycle against a
// byte-array memory model and the per-transfer response timing rules.
module tb_ahb_sram_slave;

  localparam int          TB_WAIT   = 3;
  localparam int          TB_DEPTH  = 64;
  localparam int          MEM_BYTES = TB_DEPTH * 4;
  localparam logic [31:0] TB_BASE   = 32'h0000_0400;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic        hclk;
  logic        hreset = 1'b0;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        hold_off;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  beat_t       q[$];
  logic [31:0] rd_log[$];

  assign hready_in = hreadyout & ~hold_off;

  ahb_sram_slave #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_DEPTH  (TB_DEPTH),
    .BASE_ADDR  (TB_BASE),
    .WAIT_STATES(TB_WAIT)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hwdata   (hwdata),
    .hready_in(hready_in),
    .hrdata   (hrdata),
    .hreadyout(hreadyout),
    .hresp    (hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(logic sel, logic [1:0] tr, logic [31:0] a, logic wr,
                               logic [2:0] sz, logic [31:0] d);
    beat_t b;
    b.sel = sel; b.trans = tr; b.addr = a; b.wr = wr; b.size = sz; b.wdata = d;
    return b;
  endfunction

  function automatic bit classify(beat_t b);
    return (b.addr >= TB_BASE) && (b.addr - TB_BASE < 32'(MEM_BYTES)) &&
           (b.size <= 3'd2) && ((b.addr % (32'd1 << b.size)) == 32'd0);
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] addr);
    int off;
    off = int'(addr - TB_BASE) & ~3;
    return {ref_mem[off+3], ref_mem[off+2], ref_mem[off+1], ref_mem[off]};
  endfunction

  task automatic ref_write(beat_t b);
    int off, lane;
    off  = int'(b.addr - TB_BASE);
    lane = int'(b.addr % 4);
    for (int k = 0; k < (1 << b.size); k++) ref_mem[off+k] = b.wdata[8*(lane+k) +: 8];
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = T_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;
  endtask

  task automatic drive_addr(beat_t b);
    hsel = b.sel; htrans = b.trans; haddr = b.addr; hwrite = b.wr; hsize = b.size;
    hburst = 3'($urandom_range(0, 7));
  endtask

  // Plays the queued beats as a pipelined master; entered and left at posedge + 1.
  task automatic run_q(output int data_cycles);
    int          i = 0;
    int          cyc = 0;
    int          dp_cyc = 0;
    int          budget;
    bit          dp_act = 0;
    bit          dp_ok = 0;
    beat_t       dp;
    logic [31:0] rd, e_rd;
    logic        rdy, rsp, e_rdy, e_rsp;
    budget      = q.size() * (TB_WAIT + 2) + 8;
    data_cycles = 0;
    dp          = '0;
    while (i < q.size() || dp_act) begin
      if (cyc > budget) begin
        check("timeout", 32'(cyc), 32'(budget));
        break;
      end
      cyc++;
      if (i < q.size()) drive_addr(q[i]);
      else              drive_idle();
      hwdata = (dp_act && dp.wr) ? dp.wdata : $urandom;
      @(negedge hclk);
      rdy = hreadyout; rsp = hresp; rd = hrdata;
      e_rdy = 1'b1; e_rsp = 1'b0; e_rd = '0;
      if (dp_act) begin
        data_cycles++;
        if (dp_ok) begin
          e_rdy = (dp_cyc == TB_WAIT);
          if (e_rdy && !dp.wr) e_rd = ref_word(dp.addr);
        end else begin
          e_rdy = (dp_cyc == 1);
          e_rsp = 1'b1;
        end
      end
      check("hreadyout", 32'(rdy), 32'(e_rdy));
      check("hresp", 32'(rsp), 32'(e_rsp));
      check("hrdata", rd, e_rd);
      @(posedge hclk);
      #1;
      if (dp_act && rdy) begin
        if (dp_ok && dp.wr)  ref_write(dp);
        if (dp_ok && !dp.wr) rd_log.push_back(rd);
        dp_act = 0;
      end else if (dp_act) begin
        dp_cyc++;
      end
      if (rdy && i < q.size()) begin
        if (q[i].sel && q[i].trans[1]) begin
          dp = q[i]; dp_act = 1; dp_cyc = 0; dp_ok = classify(q[i]);
        end
        i++;
      end
    end
    drive_idle();
    q.delete();
  endtask

  initial begin
    int          dc;
    int          off;
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;
    drive_idle();
    hold_off = 1'b0;
    hwdata   = '0;
    #1 hreset = 1'b1;
    #12;
    check("reset_hreadyout", 32'(hreadyout), 32'd1);
    check("reset_hresp", 32'(hresp), 32'd0);
    check("reset_hrdata", hrdata, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    for (int w = 0; w < TB_DEPTH; w++)
      q.push_back(mk(1, T_NSEQ, TB_BASE + 32'(4*w), 1, 3'd2, $urandom));
    run_q(dc);

    rd_log.delete();
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h10, 1, 3'd2, 32'hDEAD_BEEF));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h10, 0, 3'd2, 32'h0));
    run_q(dc);
    check("wr_then_rd", rd_log[$], 32'hDEAD_BEEF);

    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h14, 0, 3'd2, 32'h0));
    run_q(dc);
    check("single_rd_cycles", 32'(dc), 32'd4);
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h20, 0, 3'd2, 32'h0));
    q.push_back(mk(1, T_SEQ,  TB_BASE + 32'h24, 0, 3'd2, 32'h0));
    q.push_back(mk(1, T_SEQ,  TB_BASE + 32'h28, 0, 3'd2, 32'h0));
    q.push_back(mk(1, T_SEQ,  TB_BASE + 32'h2C, 0, 3'd2, 32'h0));
    run_q(dc);
    check("incr4_cycles", 32'(dc), 32'd16);

    rd_log.delete();
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h10, 1, 3'd2, 32'h1122_3344));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h13, 1, 3'd0, 32'hAA00_0000));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h10, 0, 3'd2, 32'h0));
    run_q(dc);
    check("byte_merge", rd_log[$], 32'hAA22_3344);

    rd_log.delete();
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'(MEM_BYTES), 0, 3'd2, 32'h0));
    q.push_back(mk(1, T_NSEQ, TB_BASE - 32'd4, 0, 3'd2, 32'h0));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h1, 0, 3'd1, 32'h0));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h8, 1, 3'd3, 32'h0));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h10, 0, 3'd2, 32'h0));
    run_q(dc);
    check("err_then_okay", rd_log[$], 32'hAA22_3344);
    check("err_seq_cycles", 32'(dc), 32'd12);

    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h40, 1, 3'd2, $urandom));
    q.push_back(mk(1, T_BUSY, TB_BASE + 32'h4C, 1, 3'd2, 32'h0));
    q.push_back(mk(1, T_SEQ,  TB_BASE + 32'h44, 1, 3'd2, $urandom));
    q.push_back(mk(1, T_IDLE, TB_BASE + 32'h4C, 1, 3'd2, 32'h0));
    q.push_back(mk(0, T_NSEQ, TB_BASE + 32'h4C, 1, 3'd2, 32'h0));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h48, 1, 3'd2, $urandom));
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h4C, 0, 3'd2, 32'h0));
    run_q(dc);

    hold_off = 1'b1;
    drive_addr(mk(1, T_NSEQ, TB_BASE + 32'h30, 0, 3'd2, 32'h0));
    @(posedge hclk); #1;
    hold_off = 1'b0;
    drive_idle();
    @(negedge hclk);
    check("hold_off_ignored", 32'(hreadyout), 32'd1);
    @(posedge hclk); #1;

    rd_log.delete();
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h20, 1, 3'd2, 32'h0000_0005));
    run_q(dc);
    drive_addr(mk(1, T_NSEQ, TB_BASE + 32'h20, 1, 3'd2, 32'h0));
    @(posedge hclk); #1;
    drive_idle();
    hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check("rst_in_wait_ready", 32'(hreadyout), 32'd0);
    #2 hreset = 1'b1;
    #1;
    check("rst_async_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_async_hrdata", hrdata, 32'd0);
    check("rst_async_hresp", 32'(hresp), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;
    q.push_back(mk(1, T_NSEQ, TB_BASE + 32'h20, 0, 3'd2, 32'h0));
    run_q(dc);
    check("rst_write_dropped", rd_log[$], 32'h0000_0005);

    for (int n = 0; n < 300; n++) begin
      beat_t b;
      b.sel   = ($urandom_range(0, 9) != 0);
      r       = $urandom_range(0, 9);
      b.trans = (r < 1) ? T_IDLE : (r < 2) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
      b.wr    = 1'($urandom_range(0, 1));
      sz      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      b.size  = sz;
      r       = $urandom_range(0, 19);
      if (r == 0) begin
        a = TB_BASE - 32'(4 * $urandom_range(1, 4));
      end else if (r == 1) begin
        a = TB_BASE + 32'(MEM_BYTES) + 32'(4 * $urandom_range(0, 3));
      end else begin
        off = $urandom_range(0, MEM_BYTES - 1);
        if (sz <= 3'd2 && $urandom_range(0, 9) != 0) off = off & ~((1 << sz) - 1);
        a = TB_BASE + 32'(off);
      end
      b.addr  = a;
      b.wdata = $urandom;
      q.push_back(b);
    end
    run_q(dc);

    for (int w = 0; w < TB_DEPTH; w++)
      q.push_back(mk(1, (w == 0) ? T_NSEQ : T_SEQ, TB_BASE + 32'(4*w), 0, 3'd2, 32'h0));
    run_q(dc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
